// File: rtl/connect4_pkg.sv
// Shared constants, codes and helpers for the connect-four board controller.
package connect4_pkg;

    localparam int unsigned ROWS      = 6;
    localparam int unsigned COLS      = 7;
    localparam int unsigned GRID_W    = ROWS * COLS * 2;
    localparam int unsigned MAX_MOVES = ROWS * COLS;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] HUMAN = 2'b01;
    localparam logic [1:0] AI    = 2'b10;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_HUMAN = 2'b01;
    localparam logic [1:0] WIN_AI    = 2'b10;
    localparam logic [1:0] WIN_DRAW  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StPlace,
        StCheck,
        StResolve,
        StOver
    } state_t;

    // Top bit index of cell (r,c); column 0 sits in the high bits of each row.
    function automatic int cell_idx(input int r, input int c);
        return r * 14 + 13 - 2 * c;
    endfunction

endpackage

// File: rtl/dir_run_count.sv
// Combinational length of the same-owner run through the placed cell along one direction.
module dir_run_count
    import connect4_pkg::*;
(
    input  logic [GRID_W-1:0] grid,
    input  logic [2:0]        row,
    input  logic [2:0]        col,
    input  logic [1:0]        owner,
    input  logic [1:0]        dir,
    output logic [2:0]        run
);

    int   dr;
    int   dc;
    logic fwd_ok;
    logic bwd_ok;

    function automatic logic owned(input logic [GRID_W-1:0] g, input logic [1:0] who,
                                   input int r, input int c);
        if (r < 0 || r >= int'(ROWS) || c < 0 || c >= int'(COLS)) begin
            return 1'b0;
        end
        return 2'(g >> (cell_idx(r, c) - 1)) == who;
    endfunction

    always_comb begin
        dr = 0;
        dc = 1;
        unique case (dir)
            2'd0:    begin dr = 0;  dc = 1; end
            2'd1:    begin dr = 1;  dc = 0; end
            2'd2:    begin dr = 1;  dc = 1; end
            default: begin dr = -1; dc = 1; end
        endcase

        run    = 3'd1;
        fwd_ok = 1'b1;
        bwd_ok = 1'b1;
        // Each side stops at the first foreign cell or board edge, three steps at most.
        for (int k = 1; k <= 3; k++) begin
            if (fwd_ok && owned(grid, owner, int'(row) + dr * k, int'(col) + dc * k)) begin
                run = run + 3'd1;
            end else begin
                fwd_ok = 1'b0;
            end
            if (bwd_ok && owned(grid, owner, int'(row) - dr * k, int'(col) - dc * k)) begin
                run = run + 3'd1;
            end else begin
                bwd_ok = 1'b0;
            end
        end
    end

endmodule

// File: rtl/board_state.sv
// Connect-four board controller: accepts alternating human/AI drops, checks for a
// four-in-a-row one direction per cycle, and tracks winner, draw and turn.
module board_state
    import connect4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              new_game,
    input  logic [2:0]        human_col,
    input  logic              human_valid,
    input  logic [6:0]        ai_opt,
    input  logic              ai_move,
    output logic [GRID_W-1:0] grid,
    output logic [20:0]       column_counts,
    output logic              player,
    output logic              busy,
    output logic              illegal,
    output logic              game_over,
    output logic [1:0]        winner
);

    state_t            state_q, state_d;
    logic [GRID_W-1:0] grid_q, grid_d;
    logic [20:0]       counts_q, counts_d;
    logic              player_q, player_d;
    logic              illegal_q, illegal_d;
    logic              over_q, over_d;
    logic              win_q, win_d;
    logic [1:0]        winner_q, winner_d;
    logic [1:0]        dir_q, dir_d;
    logic [5:0]        moves_q, moves_d;
    logic [2:0]        col_q, col_d;
    logic [2:0]        row_q, row_d;

    logic       req;
    logic       req_bad;
    logic [2:0] req_col;
    logic [2:0] req_cnt;
    logic [2:0] run;
    logic [1:0] mover;

    assign mover = player_q ? AI : HUMAN;

    // Only the strobe of the side to move is considered; the other is ignored.
    always_comb begin
        req     = 1'b0;
        req_bad = 1'b0;
        req_col = human_col;
        if (!player_q) begin
            req     = human_valid;
            req_bad = human_col > 3'd6;
        end else begin
            req     = ai_move;
            req_col = 3'((13 - int'(ai_opt) % 14) / 2);
            req_bad = (ai_opt >= 7'd84) || !ai_opt[0];
        end
        req_cnt = 3'(counts_q >> (3 * int'(req_col)));
        if (req_cnt == 3'(ROWS)) begin
            req_bad = 1'b1;
        end
    end

    dir_run_count u_run (
        .grid  (grid_q),
        .row   (row_q),
        .col   (col_q),
        .owner (mover),
        .dir   (dir_q),
        .run   (run)
    );

    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        counts_d  = counts_q;
        player_d  = player_q;
        illegal_d = 1'b0;
        over_d    = over_q;
        win_d     = win_q;
        winner_d  = winner_q;
        dir_d     = dir_q;
        moves_d   = moves_q;
        col_d     = col_q;
        row_d     = row_q;

        if (new_game) begin
            state_d  = StIdle;
            grid_d   = '0;
            counts_d = '0;
            player_d = 1'b0;
            over_d   = 1'b0;
            win_d    = 1'b0;
            winner_d = WIN_NONE;
            dir_d    = 2'd0;
            moves_d  = 6'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req && !over_q) begin
                        if (req_bad) begin
                            illegal_d = 1'b1;
                        end else begin
                            col_d   = req_col;
                            row_d   = req_cnt;
                            win_d   = 1'b0;
                            dir_d   = 2'd0;
                            state_d = StPlace;
                        end
                    end
                end
                StPlace: begin
                    grid_d   = grid_q | ({{(GRID_W - 2){1'b0}}, mover}
                                         << (cell_idx(int'(row_q), int'(col_q)) - 1));
                    counts_d = counts_q + (21'd1 << (3 * int'(col_q)));
                    moves_d  = (moves_q == 6'(MAX_MOVES)) ? moves_q : moves_q + 6'd1;
                    dir_d    = 2'd0;
                    state_d  = StCheck;
                end
                StCheck: begin
                    if (run >= 3'd4) begin
                        win_d = 1'b1;
                    end
                    dir_d = dir_q + 2'd1;
                    if (dir_q == 2'd3) begin
                        state_d = StResolve;
                    end
                end
                StResolve: begin
                    if (win_q) begin
                        winner_d = player_q ? WIN_AI : WIN_HUMAN;
                        over_d   = 1'b1;
                        state_d  = StOver;
                    end else if (moves_q == 6'(MAX_MOVES)) begin
                        winner_d = WIN_DRAW;
                        over_d   = 1'b1;
                        state_d  = StOver;
                    end else begin
                        player_d = !player_q;
                        state_d  = StIdle;
                    end
                end
                StOver: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            grid_q    <= '0;
            counts_q  <= '0;
            player_q  <= 1'b0;
            illegal_q <= 1'b0;
            over_q    <= 1'b0;
            win_q     <= 1'b0;
            winner_q  <= WIN_NONE;
            dir_q     <= 2'd0;
            moves_q   <= 6'd0;
            col_q     <= 3'd0;
            row_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            counts_q  <= counts_d;
            player_q  <= player_d;
            illegal_q <= illegal_d;
            over_q    <= over_d;
            win_q     <= win_d;
            winner_q  <= winner_d;
            dir_q     <= dir_d;
            moves_q   <= moves_d;
            col_q     <= col_d;
            row_q     <= row_d;
        end
    end

    assign grid          = grid_q;
    assign column_counts = counts_q;
    assign player        = player_q;
    assign busy          = (state_q == StPlace) || (state_q == StCheck) || (state_q == StResolve);
    assign illegal       = illegal_q;
    assign game_over     = over_q;
    assign winner        = winner_q;

endmodule

// File: tb/tb_board_state.sv
// Scoreboard bench for board_state: a board model predicts each move's outcome.
module tb_board_state;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_game = 1'b0;
    logic [2:0]  human_col = 3'd0;
    logic        human_valid = 1'b0;
    logic [6:0]  ai_opt = 7'd0;
    logic        ai_move = 1'b0;
    logic [83:0] grid;
    logic [20:0] column_counts;
    logic        player;
    logic        busy;
    logic        illegal;
    logic        game_over;
    logic [1:0]  winner;

    board_state dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .new_game      (new_game),
        .human_col     (human_col),
        .human_valid   (human_valid),
        .ai_opt        (ai_opt),
        .ai_move       (ai_move),
        .grid          (grid),
        .column_counts (column_counts),
        .player        (player),
        .busy          (busy),
        .illegal       (illegal),
        .game_over     (game_over),
        .winner        (winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [83:0] grid;
        logic [20:0] counts;
        logic        player;
        logic [1:0]  winner;
        logic        over;
        logic        ill;
        logic        acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int   cell_m[6][7];
    int   h_m[7];
    int   moves_m;
    bit   player_m;
    logic [1:0] winner_m;
    bit   over_m;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 6; r++) for (int c = 0; c < 7; c++) cell_m[r][c] = 0;
        for (int c = 0; c < 7; c++) h_m[c] = 0;
        moves_m  = 0;
        player_m = 0;
        winner_m = 2'b00;
        over_m   = 0;
    endtask

    // Whole-board scan for any four-in-a-row of the given owner.
    function automatic bit model_win(input int who);
        int drs[4];
        int dcs[4];
        int rr;
        int cc;
        bit ok;
        drs = '{0, 1, 1, -1};
        dcs = '{1, 0, 1, 1};
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 7; c++) begin
                for (int d = 0; d < 4; d++) begin
                    ok = 1;
                    for (int k = 0; k < 4; k++) begin
                        rr = r + drs[d] * k;
                        cc = c + dcs[d] * k;
                        if (rr < 0 || rr > 5 || cc > 6) ok = 0;
                        else if (cell_m[rr][cc] != who) ok = 0;
                    end
                    if (ok) return 1;
                end
            end
        end
        return 0;
    endfunction

    function automatic logic [83:0] model_grid();
        logic [83:0] g;
        g = '0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++) g[r * 14 + 12 - 2 * c +: 2] = 2'(cell_m[r][c]);
        return g;
    endfunction

    function automatic logic [20:0] model_counts();
        logic [20:0] v;
        v = '0;
        for (int c = 0; c < 7; c++) v[c * 3 +: 3] = 3'(h_m[c]);
        return v;
    endfunction

    function automatic int opt_for(input int c, input int k);
        return 13 - 2 * c + 14 * (k % 6);
    endfunction

    // Predict, push, drive one strobe, wait for completion, pop and compare.
    task automatic do_move(input bit ai, input int val, input string tag);
        exp_t e;
        exp_t got;
        int   c;
        bit   acc;
        bit   ill;
        acc = 0;
        ill = 0;
        c   = 0;
        if (!over_m && ai == player_m) begin
            if (ai && (val >= 84 || val % 2 == 0)) ill = 1;
            else if (!ai && val > 6) ill = 1;
            else begin
                c = ai ? (13 - val % 14) / 2 : val;
                if (h_m[c] == 6) ill = 1;
                else acc = 1;
            end
        end
        if (acc) begin
            cell_m[h_m[c]][c] = ai ? 2 : 1;
            h_m[c]++;
            moves_m++;
            if (model_win(ai ? 2 : 1)) begin
                winner_m = ai ? 2'b10 : 2'b01;
                over_m   = 1;
            end else if (moves_m == 42) begin
                winner_m = 2'b11;
                over_m   = 1;
            end else begin
                player_m = !player_m;
            end
        end
        e.tag    = tag;
        e.grid   = model_grid();
        e.counts = model_counts();
        e.player = player_m;
        e.winner = winner_m;
        e.over   = over_m;
        e.ill    = ill;
        e.acc    = acc;
        exp_q.push_back(e);

        @(negedge clk);
        if (ai) begin
            ai_move = 1'b1;
            ai_opt  = 7'(val);
        end else begin
            human_valid = 1'b1;
            human_col   = 3'(val);
        end
        @(negedge clk);
        human_valid = 1'b0;
        ai_move     = 1'b0;
        check_eq({tag, " illegal"}, illegal, ill);
        check_eq({tag, " busy"}, busy, acc);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check_eq({tag, " done"}, busy, 1'b0);

        got = exp_q.pop_front();
        check_eq({got.tag, " grid"}, grid, got.grid);
        check_eq({got.tag, " counts"}, column_counts, got.counts);
        check_eq({got.tag, " player"}, player, got.player);
        check_eq({got.tag, " winner"}, winner, got.winner);
        check_eq({got.tag, " game_over"}, game_over, got.over);
    endtask

    task automatic start_new_game(input string tag);
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
        check_eq({tag, " grid"}, grid, 84'd0);
        check_eq({tag, " counts"}, column_counts, 21'd0);
        check_eq({tag, " player"}, player, 1'b0);
        check_eq({tag, " winner"}, winner, 2'b00);
        check_eq({tag, " over"}, game_over, 1'b0);
        check_eq({tag, " busy"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_eq("reset grid", grid, 84'd0);
        check_eq("reset counts", column_counts, 21'd0);
        check_eq("reset player", player, 1'b0);
        check_eq("reset busy", busy, 1'b0);
        check_eq("reset illegal", illegal, 1'b0);
        check_eq("reset over", game_over, 1'b0);
        check_eq("reset winner", winner, 2'b00);

        // Cycle-exact first move into column 3.
        @(negedge clk);
        human_valid = 1'b1;
        human_col   = 3'd3;
        @(negedge clk);
        human_valid = 1'b0;
        check_eq("t1 busy", busy, 1'b1);
        @(negedge clk);
        check_eq("t2 cell", grid[7:6], 2'b01);
        check_eq("t2 count", column_counts[11:9], 3'd1);
        repeat (4) @(negedge clk);
        check_eq("t6 busy", busy, 1'b1);
        check_eq("t6 player", player, 1'b0);
        @(negedge clk);
        check_eq("t7 player", player, 1'b1);
        check_eq("t7 busy", busy, 1'b0);
        start_new_game("ng1");

        // Vertical human win in column 0.
        for (int i = 0; i < 3; i++) begin
            do_move(0, 0, "win h0");
            do_move(1, 11, "win a11");
        end
        do_move(0, 0, "win h0 last");
        check_eq("win winner", winner, 2'b01);
        check_eq("win over", game_over, 1'b1);
        do_move(1, 11, "over a11");
        do_move(0, 1, "over h1");
        start_new_game("ng2");

        // Column full and AI encoding errors.
        for (int i = 0; i < 3; i++) begin
            do_move(0, 2, "fill h2");
            do_move(1, 9, "fill a9");
        end
        do_move(0, 2, "full h2");
        do_move(0, 7, "bad h7");
        do_move(0, 0, "ok h0");
        do_move(1, 6, "even a6");
        do_move(1, 90, "range a90");
        do_move(1, 84, "range a84");
        do_move(0, 1, "wrong turn h1");
        do_move(1, 25, "row ignored a25");
        do_move(0, 3, "ok h3");
        do_move(1, 9, "full a9");
        do_move(1, 11, "ok a11");
        start_new_game("ng3");

        // Striped 42-move fill with no four-in-a-row.
        for (int r = 0; r < 6; r++) begin
            for (int p = 0; p < 3; p++) begin
                int hc;
                int ac;
                hc = (((r / 2) % 2) == 0) ? 2 * p : 2 * p + 1;
                ac = (hc == 2 * p) ? 2 * p + 1 : 2 * p;
                do_move(0, hc, "draw h");
                do_move(1, opt_for(ac, moves_m), "draw a");
            end
        end
        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 0) do_move(0, 6, "draw h6");
            else do_move(1, opt_for(6, moves_m), "draw a6");
        end
        check_eq("draw winner", winner, 2'b11);
        check_eq("draw over", game_over, 1'b1);
        start_new_game("ng4");

        // new_game during CHECK of a winning move.
        for (int i = 0; i < 3; i++) begin
            do_move(0, 0, "abort h0");
            do_move(1, 11, "abort a11");
        end
        @(negedge clk);
        human_valid = 1'b1;
        human_col   = 3'd0;
        @(negedge clk);
        human_valid = 1'b0;
        repeat (2) @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check_eq("abort grid", grid, 84'd0);
        check_eq("abort winner", winner, 2'b00);
        check_eq("abort player", player, 1'b0);
        check_eq("abort busy", busy, 1'b0);
        repeat (6) @(negedge clk);
        check_eq("abort late winner", winner, 2'b00);
        check_eq("abort late over", game_over, 1'b0);
        model_clear();

        // Strobe coincident with new_game is discarded.
        @(negedge clk);
        new_game    = 1'b1;
        human_valid = 1'b1;
        human_col   = 3'd4;
        @(negedge clk);
        new_game    = 1'b0;
        human_valid = 1'b0;
        check_eq("coincident busy", busy, 1'b0);
        check_eq("coincident counts", column_counts, 21'd0);

        // Reset mid-move leaves nothing behind.
        @(negedge clk);
        human_valid = 1'b1;
        human_col   = 3'd5;
        @(negedge clk);
        human_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst mid grid", grid, 84'd0);
        check_eq("rst mid counts", column_counts, 21'd0);
        check_eq("rst mid busy", busy, 1'b0);
        check_eq("rst mid player", player, 1'b0);
        repeat (6) @(negedge clk);
        check_eq("rst mid late grid", grid, 84'd0);
        model_clear();
        do_move(0, 5, "post rst h5");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/board_state.md
BOARD_STATE -- requirements
Module: board_state

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state updates on posedge clk.
REQ-002 SHALL have port: rst_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-003 SHALL have port: new_game  in  1  synchronous board clear.
REQ-004 SHALL have ports: human_col  in  3  human column 0..6; human_valid  in  1  single-cycle move request.
REQ-005 SHALL have ports: ai_opt  in  7  top bit index of AI target cell; ai_move  in  1  single-cycle AI move strobe.
REQ-006 SHALL have port: grid  out  84  board, cell (row r, col c) at bits [r*14+13-2c -: 2]; 00 empty, 01 human, 10 AI; row 0 bottom.
REQ-007 SHALL have port: column_counts  out  21  discs per column, column c at [c*3+2 -: 3].
REQ-008 SHALL have ports: player  out  1  (0 human turn, 1 AI turn); busy  out  1; illegal  out  1 (one-cycle pulse); game_over  out  1; winner  out  2 (00 none, 01 human, 10 AI, 11 draw).

Function
REQ-009 SHALL implement states IDLE, PLACE, CHECK (4 cycles, one direction each: horizontal, vertical, diagonal-up, diagonal-down), RESOLVE, OVER.
REQ-010 In IDLE with game_over=0, SHALL accept human_valid only when player=0 and ai_move only when player=1; the strobe for the other player is ignored with no illegal pulse.
REQ-011 For an AI move, SHALL derive column = (13 - ai_opt mod 14)/2 and ignore the row encoded in ai_opt; the disc drops to row column_counts[c].
REQ-012 SHALL reject, with illegal=1 for the cycle after the strobe and no other state change: human_col>6; target column count=6; ai_opt>=84; or ai_opt even.
REQ-013 On an accepted strobe at cycle N: latch the column; enter PLACE at N+1, writing the cell and incrementing the column count (visible at N+2); CHECK occupies N+2..N+5; RESOLVE at N+6.
REQ-014 CHECK SHALL count, for the current direction, consecutive same-owner cells on both sides of the placed cell, up to 3 each side and bounded by the board edges; a total including the placed cell >=4 sets a sticky win flag.
REQ-015 In RESOLVE: if win, set winner to the mover's code and game_over=1, and enter OVER; else, if the move counter reaches 42, set winner=11 and game_over=1, and enter OVER; else toggle player and return to IDLE.
REQ-016 The move counter SHALL be 6 bits, incremented in PLACE, range 0..42, never wrapping.
REQ-017 busy SHALL be 1 in PLACE, CHECK and RESOLVE, and 0 in IDLE and OVER.
REQ-018 OVER SHALL hold grid, counts, winner and player until new_game or reset, and SHALL ignore all move strobes without pulsing illegal.
REQ-019 new_game SHALL, in any state including mid-CHECK, clear grid, counts, move counter and winner, set player=0 and game_over=0, and enter IDLE next cycle; a strobe coincident with new_game is discarded.
REQ-020 Priority SHALL be rst_n, then new_game, then move strobes.
REQ-021 A strobe arriving while busy=1 SHALL be dropped silently; strobe sources are required to wait for busy=0.

Reset
REQ-022 With rst_n=0 at a posedge: grid=0, column_counts=0, player=0, busy=0, illegal=0, game_over=0, winner=00, move counter=0, state=IDLE.
REQ-023 Reset asserted mid-operation SHALL abandon the move with no partial update visible after the reset edge.

Structure
REQ-024 A shared package connect4_pkg SHALL hold ROWS=6, COLS=7, cell codes EMPTY/HUMAN/AI, winner codes, the state enum, and a cell-index function (r,c)->r*14+13-2c.
REQ-025 Sub-module dir_run_count SHALL take grid, placed row/col, owner and direction, and return the combinational run length 1..7; board_state SHALL instantiate it once and sequence the direction through CHECK.

Verification
REQ-026 Reset; human_col=3 strobe -> at N+2, grid[7:6]=01 and column_counts[11:9]=1; at N+7, player=1 and busy=0.
REQ-027 Human plays columns 0,0,0,0 with AI ai_opt=11 (col 1) between -> after the 4th human move, winner=01, game_over=1, and later AI strobes are ignored.
REQ-028 Six drops into column 2, then a 7th strobe for column 2 -> illegal pulses one cycle; grid and player are unchanged.
REQ-029 AI turn with ai_opt=6 (even) or ai_opt=90 -> illegal=1; human_valid during the AI turn -> no effect.
REQ-030 A 42-move fill with no four-in-a-row -> winner=11 and game_over=1.
REQ-031 new_game asserted during CHECK of a winning move -> grid=0, winner=00, player=0, and IDLE next cycle.
